uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a parallel word as START / DATA / [PARITY] / STOP
// around an external serializer, with a 1-deep hold buffer for back-to-back frames.
`timescale 1ns/1ps
module uart_tx_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int SER_TIMEOUT = 9
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_Data,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  ser_data,
  input  logic                  ser_done,
  output logic                  ser_en,
  output logic                  Ser_Load,
  output logic [DATA_WIDTH-1:0] Ser_P_Data,
  output logic                  TX_OUT,
  output logic                  Busy,
  output logic                  Overrun,
  output logic                  Frame_Err
);

  localparam int CW = $clog2(SER_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // Parity type is folded into par_bit at capture, so it is not kept separately.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  par_en;
    logic                  par_bit;
  } word_t;

  state_t        state;
  word_t         frame, hold;
  logic          pending;
  logic [CW-1:0] cnt;

  function automatic word_t mk_word(input logic [DATA_WIDTH-1:0] d,
                                    input logic en, input logic typ);
    word_t w;
    w.data    = d;
    w.par_en  = en;
    w.par_bit = (^d) ^ typ;
    return w;
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      frame     <= '0;
      hold      <= '0;
      pending   <= 1'b0;
      cnt       <= '0;
      Overrun   <= 1'b0;
      Frame_Err <= 1'b0;
    end else begin
      Overrun   <= 1'b0;
      Frame_Err <= 1'b0;
      case (state)
        IDLE: begin
          if (pending) begin
            frame   <= hold;
            state   <= START;
            pending <= Data_Valid;
            if (Data_Valid) hold <= mk_word(P_Data, PAR_EN, PAR_TYP);
          end else if (Data_Valid) begin
            frame <= mk_word(P_Data, PAR_EN, PAR_TYP);
            state <= START;
          end
        end
        START: begin
          cnt   <= '0;
          state <= DATA;
        end
        DATA: begin
          if (ser_done) begin
            state <= frame.par_en ? PARITY : STOP;
          end else if (cnt == CW'(SER_TIMEOUT - 1)) begin
            state     <= STOP;
            Frame_Err <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PARITY: state <= STOP;
        STOP: begin
          // A word arriving in STOP with the buffer empty goes straight to the frame.
          if (pending) begin
            frame   <= hold;
            pending <= 1'b0;
            state   <= START;
          end else if (Data_Valid) begin
            frame <= mk_word(P_Data, PAR_EN, PAR_TYP);
            state <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (state != IDLE && Data_Valid) begin
        if (pending) begin
          Overrun <= 1'b1;
        end else if (state != STOP) begin
          hold    <= mk_word(P_Data, PAR_EN, PAR_TYP);
          pending <= 1'b1;
        end
      end
    end
  end

  assign Busy       = (state != IDLE);
  assign ser_en     = (state == DATA);
  assign Ser_Load   = (state == START);
  assign Ser_P_Data = frame.data;

  always_comb begin
    TX_OUT = 1'b1;
    case (state)
      IDLE:    TX_OUT = 1'b1;
      START:   TX_OUT = 1'b0;
      DATA:    TX_OUT = ser_data;
      PARITY:  TX_OUT = frame.par_bit;
      STOP:    TX_OUT = 1'b1;
      default: TX_OUT = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: expected TX_OUT bit streams are queued when a word is
// sent and popped by a line monitor each busy cycle; control strobes are checked inline.
`timescale 1ns/1ps
module tb_uart_tx_ctrl;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] P_Data = '0;
  logic          Data_Valid = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          ser_data, ser_done;
  logic          ser_en, Ser_Load, TX_OUT, Busy, Overrun, Frame_Err;
  logic [DW-1:0] Ser_P_Data;

  int cmp_cnt = 0;
  int err_cnt = 0;
  logic exp_q[$];
  logic mon_en = 1'b1;

  // serializer model: LSB first, ser_done on the 8th DATA cycle unless suppressed
  logic [DW-1:0] sh = '0;
  int            idx = 0;
  logic          no_done = 1'b0;

  uart_tx_ctrl #(.DATA_WIDTH(DW), .SER_TIMEOUT(9)) dut (
    .CLK(CLK), .RST(RST), .P_Data(P_Data), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .ser_data(ser_data), .ser_done(ser_done),
    .ser_en(ser_en), .Ser_Load(Ser_Load), .Ser_P_Data(Ser_P_Data), .TX_OUT(TX_OUT),
    .Busy(Busy), .Overrun(Overrun), .Frame_Err(Frame_Err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (Ser_Load) begin
      sh  <= Ser_P_Data;
      idx <= 0;
    end else if (ser_en) begin
      sh  <= sh >> 1;
      idx <= idx + 1;
    end
  end
  assign ser_data = sh[0];
  assign ser_done = ser_en && (idx == DW - 1) && !no_done;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && mon_en && Busy) begin
      if (exp_q.size() == 0) check("tx_unexpected_busy", 32'(Busy), 32'd0);
      else check("tx_bit", 32'(TX_OUT), 32'(exp_q.pop_front()));
    end
  end

  function automatic void push_frame(input logic [DW-1:0] d, input logic en,
                                     input logic typ, input logic tmo);
    exp_q.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
    if (tmo) exp_q.push_back(1'b0);
    else if (en) exp_q.push_back((^d) ^ typ);
    exp_q.push_back(1'b1);
  endfunction

  // caller is at a negedge; returns at the following negedge with Data_Valid low
  task automatic pulse(input logic [DW-1:0] d, input logic en, input logic typ);
    P_Data = d; PAR_EN = en; PAR_TYP = typ; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (Busy && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check({tag, "_idle"}, 32'(Busy), 32'd0);
    check({tag, "_qempty"}, 32'(exp_q.size()), 32'd0);
    @(negedge CLK);
  endtask

  initial begin
    int n;
    #2;
    check("rst_tx", 32'(TX_OUT), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_seren", 32'(ser_en), 32'd0);
    check("rst_load", 32'(Ser_Load), 32'd0);
    check("rst_pdata", 32'(Ser_P_Data), 32'd0);
    check("rst_ovr", 32'(Overrun), 32'd0);
    check("rst_ferr", 32'(Frame_Err), 32'd0);
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);

    // even parity, odd parity, no parity
    push_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    pulse(8'hA5, 1'b1, 1'b0);
    check("a5_load", 32'(Ser_Load), 32'd1);
    check("a5_pdata", 32'(Ser_P_Data), 32'hA5);
    wait_idle("a5_even");
    push_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    pulse(8'hA5, 1'b1, 1'b1);
    wait_idle("a5_odd");
    push_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    pulse(8'hA5, 1'b0, 1'b0);
    wait_idle("a5_nopar");
    push_frame(8'h00, 1'b1, 1'b1, 1'b0);
    pulse(8'h00, 1'b1, 1'b1);
    wait_idle("zero_odd");

    // back-to-back: 0x3C queued while 0xA5 is in DATA
    push_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    pulse(8'hA5, 1'b1, 1'b0);
    repeat (3) @(negedge CLK);
    push_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    pulse(8'h3C, 1'b1, 1'b0);
    check("b2b_no_ovr", 32'(Overrun), 32'd0);
    n = 0;
    while (!Ser_Load && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_gap", 32'(n), 32'd7);
    check("b2b_pdata", 32'(Ser_P_Data), 32'h3C);
    check("b2b_start_tx", 32'(TX_OUT), 32'd0);
    wait_idle("b2b");

    // three words during one frame: first kept, next two dropped
    push_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    pulse(8'hA5, 1'b1, 1'b0);
    @(negedge CLK);
    push_frame(8'h11, 1'b0, 1'b0, 1'b0);
    pulse(8'h11, 1'b0, 1'b0);
    check("ovr_first", 32'(Overrun), 32'd0);
    pulse(8'h22, 1'b1, 1'b0);
    check("ovr_second", 32'(Overrun), 32'd1);
    @(negedge CLK);
    check("ovr_gap", 32'(Overrun), 32'd0);
    pulse(8'h33, 1'b1, 1'b1);
    check("ovr_third", 32'(Overrun), 32'd1);
    @(negedge CLK);
    check("ovr_single", 32'(Overrun), 32'd0);
    wait_idle("ovr");

    // serializer never reports done
    no_done = 1'b1;
    push_frame(8'hA5, 1'b1, 1'b0, 1'b1);
    pulse(8'hA5, 1'b1, 1'b0);
    n = 0;
    while (!Frame_Err && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'd10);
    check("tmo_tx", 32'(TX_OUT), 32'd1);
    @(negedge CLK);
    check("tmo_ferr_single", 32'(Frame_Err), 32'd0);
    check("tmo_idle", 32'(Busy), 32'd0);
    no_done = 1'b0;
    wait_idle("tmo");

    // asynchronous reset mid-frame with a word pending
    mon_en = 1'b0;
    pulse(8'h5A, 1'b1, 1'b0);
    @(negedge CLK);
    pulse(8'hC3, 1'b1, 1'b0);
    check("arst_in_data", 32'(ser_en), 32'd1);
    #2 RST = 1'b1;
    #1;
    check("arst_tx", 32'(TX_OUT), 32'd1);
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_seren", 32'(ser_en), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    n = 0;
    repeat (20) begin
      @(negedge CLK);
      if (Busy) n++;
    end
    check("arst_no_tx", 32'(n), 32'd0);
    mon_en = 1'b1;

    push_frame(8'h96, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    pulse(8'h96, 1'b1, 1'b1);
    wait_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
